// File: rtl/rv_plic_target_array_pkg.sv
// Shared types for the multi-target PLIC core.
package rv_plic_target_array_pkg;

  typedef enum logic [1:0] {
    GwIdle   = 2'b00,
    GwPend   = 2'b01,
    GwActive = 2'b10
  } gw_state_e;

endpackage

// File: rtl/rv_plic_target_array_if.sv
// Source, configuration and claim/complete signals between the PLIC core and its register file.
interface rv_plic_target_array_if #(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned N_TARGET = 2,
  parameter int unsigned MAX_PRIO = 7
);
  localparam int unsigned SrcWidth  = $clog2(N_SOURCE);
  localparam int unsigned PrioWidth = $clog2(MAX_PRIO + 1);

  logic [N_SOURCE-1:0]                intr_src_i;
  logic [N_SOURCE-1:0]                le_i;
  logic [N_SOURCE-1:0][PrioWidth-1:0] prio_i;
  logic [N_TARGET-1:0][N_SOURCE-1:0]  ie_i;
  logic [N_TARGET-1:0][PrioWidth-1:0] threshold_i;
  logic [N_TARGET-1:0]                claim_re_i;
  logic [N_TARGET-1:0][SrcWidth-1:0]  claim_id_o;
  logic [N_TARGET-1:0]                complete_we_i;
  logic [N_TARGET-1:0][SrcWidth-1:0]  complete_id_i;
  logic [N_SOURCE-1:0]                ip_o;
  logic [N_TARGET-1:0]                irq_o;
  logic [N_TARGET-1:0][SrcWidth-1:0]  irq_id_o;

  modport master (
    output intr_src_i, le_i, prio_i, ie_i, threshold_i, claim_re_i, complete_we_i, complete_id_i,
    input  claim_id_o, ip_o, irq_o, irq_id_o
  );

  modport slave (
    input  intr_src_i, le_i, prio_i, ie_i, threshold_i, claim_re_i, complete_we_i, complete_id_i,
    output claim_id_o, ip_o, irq_o, irq_id_o
  );

endinterface

// File: rtl/prim_max_tree.sv
// Binary max tree over valid entries; on equal values the lower index wins.
module prim_max_tree #(
  parameter int unsigned NumSrc = 32,
  parameter int unsigned Width  = 3
) (
  input  logic [NumSrc-1:0][Width-1:0]        values,
  input  logic [NumSrc-1:0]                   valid,
  output logic [Width-1:0]                    max_value,
  output logic [$clog2(NumSrc)-1:0]           max_idx,
  output logic                                max_valid
);
  localparam int unsigned IdxWidth  = $clog2(NumSrc);
  localparam int unsigned NumLevels = (NumSrc > 1) ? $clog2(NumSrc) : 1;
  localparam int unsigned NumPad    = 2 ** NumLevels;

  logic [NumPad-1:0]                vld;
  logic [NumPad-1:0][Width-1:0]     val;
  logic [NumPad-1:0][IdxWidth-1:0]  idx;

  // Reduced in place: node i of a level only overwrites a slot already consumed.
  always_comb begin
    vld = '0;
    val = '0;
    idx = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      vld[i] = valid[i];
      val[i] = values[i];
      idx[i] = IdxWidth'(i);
    end
    for (int unsigned l = 0; l < NumLevels; l++) begin
      for (int unsigned i = 0; i < (NumPad >> (l + 1)); i++) begin
        if (vld[2*i] && (!vld[2*i+1] || (val[2*i] >= val[2*i+1]))) begin
          vld[i] = vld[2*i];
          val[i] = val[2*i];
          idx[i] = idx[2*i];
        end else begin
          vld[i] = vld[2*i+1];
          val[i] = val[2*i+1];
          idx[i] = idx[2*i+1];
        end
      end
    end
  end

  assign max_valid = vld[0];
  assign max_value = val[0];
  assign max_idx   = idx[0];

endmodule

// File: rtl/rv_plic_gateway.sv
// Per-source interrupt gateway: level/edge capture, claim/complete lifecycle, edge re-pend latch.
module rv_plic_gateway
  import rv_plic_target_array_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src,
  input  logic le,
  input  logic claim,
  input  logic complete,
  output logic ip
);
  gw_state_e state_q, state_d;
  logic      src_q;
  logic      latch_q, latch_d;
  logic      rise;

  assign rise = src & ~src_q;

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    unique case (state_q)
      GwIdle: begin
        if (le ? rise : src) state_d = GwPend;
      end
      GwPend: begin
        if (le && rise) latch_d = 1'b1;
        if (claim) state_d = GwActive;
      end
      GwActive: begin
        if (le && rise) latch_d = 1'b1;
        // Edges seen while busy collapse into a single re-pend on completion.
        if (complete) begin
          if (le && (latch_q || rise)) begin
            state_d = GwPend;
            latch_d = 1'b0;
          end else begin
            state_d = GwIdle;
          end
        end
      end
      default: state_d = GwIdle;
    endcase
    if (!le) latch_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GwIdle;
      src_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src;
      latch_q <= latch_d;
    end
  end

  assign ip = (state_q == GwPend);

endmodule

// File: rtl/rv_plic_target_array.sv
// Multi-target PLIC core: gateways, per-target priority arbitration and claim/complete handling.
module rv_plic_target_array
  import rv_plic_target_array_pkg::*;
#(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned N_TARGET = 2,
  parameter int unsigned MAX_PRIO = 7
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  rv_plic_target_array_if.slave  bus
);
  localparam int unsigned SrcWidth  = $clog2(N_SOURCE);
  localparam int unsigned PrioWidth = $clog2(MAX_PRIO + 1);

  logic [N_SOURCE-1:0]                ip;
  logic [N_SOURCE-1:0]                gw_claim;
  logic [N_SOURCE-1:0]                gw_complete;
  logic [N_TARGET-1:0][PrioWidth-1:0] max_prio;
  logic [N_TARGET-1:0][SrcWidth-1:0]  max_idx;
  logic [N_TARGET-1:0]                max_vld;
  logic [N_TARGET-1:0]                irq_d, irq_q;
  logic [N_TARGET-1:0][SrcWidth-1:0]  irq_id_d, irq_id_q;
  logic [N_TARGET-1:0]                grant;
  logic [N_TARGET-1:0][SrcWidth-1:0]  claim_id;

  // Source 0 is reserved: its gateway never sees a request or a completion.
  for (genvar s = 0; s < N_SOURCE; s++) begin : g_gw
    rv_plic_gateway u_gateway (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .src      ((s == 0) ? 1'b0 : bus.intr_src_i[s]),
      .le       (bus.le_i[s]),
      .claim    (gw_claim[s]),
      .complete (gw_complete[s]),
      .ip       (ip[s])
    );
  end

  always_comb begin
    gw_complete = '0;
    for (int unsigned s = 1; s < N_SOURCE; s++) begin
      for (int unsigned t = 0; t < N_TARGET; t++) begin
        if (bus.complete_we_i[t] && (bus.complete_id_i[t] == SrcWidth'(s))) begin
          gw_complete[s] = 1'b1;
        end
      end
    end
  end

  for (genvar t = 0; t < N_TARGET; t++) begin : g_tgt
    prim_max_tree #(
      .NumSrc (N_SOURCE),
      .Width  (PrioWidth)
    ) u_max_tree (
      .values    (bus.prio_i),
      .valid     (ip & bus.ie_i[t]),
      .max_value (max_prio[t]),
      .max_idx   (max_idx[t]),
      .max_valid (max_vld[t])
    );
  end

  always_comb begin
    irq_d    = '0;
    irq_id_d = '0;
    for (int unsigned t = 0; t < N_TARGET; t++) begin
      irq_d[t]    = max_vld[t] && (max_prio[t] > bus.threshold_i[t]);
      irq_id_d[t] = max_vld[t] ? max_idx[t] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q    <= '0;
      irq_id_q <= '0;
    end else begin
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  // Claim chain: checking live ip filters stale IDs; lower-index targets win same-ID races.
  always_comb begin
    grant    = '0;
    claim_id = '0;
    gw_claim = '0;
    for (int unsigned t = 0; t < N_TARGET; t++) begin
      if (bus.claim_re_i[t] && irq_q[t] && ip[irq_id_q[t]]) begin
        grant[t] = 1'b1;
        for (int unsigned u = 0; u < t; u++) begin
          if (grant[u] && (irq_id_q[u] == irq_id_q[t])) grant[t] = 1'b0;
        end
      end
      if (grant[t]) begin
        claim_id[t]           = irq_id_q[t];
        gw_claim[irq_id_q[t]] = 1'b1;
      end
    end
  end

  assign bus.ip_o       = ip;
  assign bus.irq_o      = irq_q;
  assign bus.irq_id_o   = irq_id_q;
  assign bus.claim_id_o = claim_id;

endmodule

// File: tb/tb_rv_plic_target_array.sv
// Directed bench for rv_plic_target_array; claim responses are checked by a scoreboard monitor.
module tb_rv_plic_target_array;
  import rv_plic_target_array_pkg::*;

  localparam int unsigned NSrc = 32;
  localparam int unsigned NTgt = 2;

  typedef struct {
    int         tgt;
    logic [4:0] id;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  exp_t exp_q[$];

  rv_plic_target_array_if #(.N_SOURCE(NSrc), .N_TARGET(NTgt), .MAX_PRIO(7)) bus ();

  rv_plic_target_array #(
    .N_SOURCE (NSrc),
    .N_TARGET (NTgt),
    .MAX_PRIO (7)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every claim strobe consumes one expected response in target order.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int t = 0; t < NTgt; t++) begin
        if (bus.claim_re_i[t]) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL claim_unexpected t%0d: got id %0d, expected no strobe", t,
                     bus.claim_id_o[t]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.tgt != t || bus.claim_id_o[t] !== e.id) begin
              n_fail++;
              $display("FAIL claim t%0d: got id %0d, expected t%0d id %0d", t,
                       bus.claim_id_o[t], e.tgt, e.id);
            end
          end
        end else if (bus.claim_id_o[t] !== 5'd0) begin
          n_vec++;
          n_fail++;
          $display("FAIL claim_idle t%0d: got id %0d, expected 0", t, bus.claim_id_o[t]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic claim(input int t, input logic [4:0] id);
    exp_q.push_back('{tgt: t, id: id});
    bus.claim_re_i[t] = 1'b1;
    step();
    bus.claim_re_i[t] = 1'b0;
  endtask

  task automatic complete(input int t, input logic [4:0] id);
    bus.complete_we_i[t] = 1'b1;
    bus.complete_id_i[t] = id;
    step();
    bus.complete_we_i[t] = 1'b0;
    bus.complete_id_i[t] = '0;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.intr_src_i    = '0;
    bus.le_i          = '0;
    bus.prio_i        = '0;
    bus.ie_i          = '0;
    bus.threshold_i   = '0;
    bus.claim_re_i    = '0;
    bus.complete_we_i = '0;
    bus.complete_id_i = '0;
    step();
    step();
    check("rst_ip", bus.ip_o, 32'h0);
    check("rst_irq", 32'(bus.irq_o), 32'h0);
    check("rst_irq_id", 32'(bus.irq_id_o), 32'h0);
    check("rst_claim_id", 32'(bus.claim_id_o), 32'h0);
    rst_n = 1'b1;
    step();

    // Level source 3: pipeline latency, claim, re-pend after completion while still high.
    bus.prio_i[3] = 3'd5;
    bus.ie_i[0][3] = 1'b1;
    bus.threshold_i[0] = 3'd2;
    bus.intr_src_i[3] = 1'b1;
    step();
    check("lvl_ip_c1", 32'(bus.ip_o[3]), 32'h1);
    check("lvl_irq_c1", 32'(bus.irq_o[0]), 32'h0);
    step();
    check("lvl_irq_c2", 32'(bus.irq_o[0]), 32'h1);
    check("lvl_id_c2", 32'(bus.irq_id_o[0]), 32'd3);
    claim(0, 5'd3);
    check("lvl_ip_active", 32'(bus.ip_o[3]), 32'h0);
    complete(0, 5'd3);
    check("lvl_ip_idle", 32'(bus.ip_o[3]), 32'h0);
    step();
    check("lvl_ip_repend", 32'(bus.ip_o[3]), 32'h1);
    bus.intr_src_i[3] = 1'b0;
    step();
    claim(0, 5'd3);
    complete(0, 5'd3);
    bus.ie_i[0][3] = 1'b0;

    // Threshold is a strict compare; priority 0 never fires.
    bus.prio_i[4] = 3'd4;
    bus.ie_i[0][4] = 1'b1;
    bus.threshold_i[0] = 3'd4;
    bus.intr_src_i[4] = 1'b1;
    step();
    step();
    check("thr_eq_irq", 32'(bus.irq_o[0]), 32'h0);
    bus.threshold_i[0] = 3'd3;
    step();
    check("thr_lt_irq", 32'(bus.irq_o[0]), 32'h1);
    check("thr_lt_id", 32'(bus.irq_id_o[0]), 32'd4);
    bus.prio_i[4] = 3'd0;
    bus.threshold_i[0] = 3'd0;
    step();
    check("prio0_irq", 32'(bus.irq_o[0]), 32'h0);
    bus.prio_i[4] = 3'd4;
    step();
    claim(0, 5'd4);
    bus.intr_src_i[4] = 1'b0;
    complete(0, 5'd4);
    bus.ie_i[0][4] = 1'b0;

    // Both targets claim source 5 together; then a stale-ID claim from target 1.
    bus.prio_i[5] = 3'd3;
    bus.ie_i[0][5] = 1'b1;
    bus.ie_i[1][5] = 1'b1;
    bus.threshold_i[1] = 3'd0;
    bus.intr_src_i[5] = 1'b1;
    step();
    step();
    check("dual_irq", 32'(bus.irq_o), 32'h3);
    check("dual_id_t1", 32'(bus.irq_id_o[1]), 32'd5);
    exp_q.push_back('{tgt: 0, id: 5'd5});
    exp_q.push_back('{tgt: 1, id: 5'd0});
    bus.claim_re_i = 2'b11;
    step();
    bus.claim_re_i = 2'b00;
    claim(1, 5'd0);
    check("dual_ip_active", 32'(bus.ip_o[5]), 32'h0);
    bus.intr_src_i[5] = 1'b0;
    complete(1, 5'd5);
    step();
    check("dual_ip_done", 32'(bus.ip_o[5]), 32'h0);
    bus.ie_i[0][5] = 1'b0;
    bus.ie_i[1][5] = 1'b0;

    // Edge source 7: three edges while active merge into one re-pend.
    bus.le_i[7] = 1'b1;
    bus.prio_i[7] = 3'd2;
    bus.ie_i[0][7] = 1'b1;
    bus.intr_src_i[7] = 1'b1;
    step();
    bus.intr_src_i[7] = 1'b0;
    check("edge_ip", 32'(bus.ip_o[7]), 32'h1);
    step();
    check("edge_id", 32'(bus.irq_id_o[0]), 32'd7);
    claim(0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      bus.intr_src_i[7] = 1'b1;
      step();
      bus.intr_src_i[7] = 1'b0;
      step();
    end
    check("edge_ip_active", 32'(bus.ip_o[7]), 32'h0);
    complete(0, 5'd7);
    check("edge_repend", 32'(bus.ip_o[7]), 32'h1);
    step();
    claim(0, 5'd7);
    complete(0, 5'd7);
    step();
    check("edge_idle_ip", 32'(bus.ip_o[7]), 32'h0);
    check("edge_idle_irq", 32'(bus.irq_o[0]), 32'h0);
    bus.ie_i[0][7] = 1'b0;

    // Equal priorities resolve to the lower ID; bogus completions are ignored.
    bus.prio_i[2] = 3'd6;
    bus.prio_i[9] = 3'd6;
    bus.ie_i[0][2] = 1'b1;
    bus.ie_i[0][9] = 1'b1;
    bus.intr_src_i[2] = 1'b1;
    bus.intr_src_i[9] = 1'b1;
    step();
    step();
    check("tie_id", 32'(bus.irq_id_o[0]), 32'd2);
    claim(0, 5'd2);
    complete(0, 5'd0);
    complete(0, 5'd9);
    check("bogus_ip9", 32'(bus.ip_o[9]), 32'h1);
    check("bogus_ip2", 32'(bus.ip_o[2]), 32'h0);
    bus.intr_src_i[2] = 1'b0;
    bus.intr_src_i[9] = 1'b0;
    complete(0, 5'd2);
    step();
    claim(0, 5'd9);
    complete(0, 5'd9);
    check("tie_all_idle", bus.ip_o, 32'h0);
    bus.ie_i[0] = '0;

    // Reset in the middle of an active claim with irq_o high.
    bus.ie_i[0][3] = 1'b1;
    bus.ie_i[0][4] = 1'b1;
    bus.intr_src_i[3] = 1'b1;
    bus.intr_src_i[4] = 1'b1;
    step();
    step();
    claim(0, 5'd3);
    step();
    check("pre_rst_irq", 32'(bus.irq_o[0]), 32'h1);
    check("pre_rst_id", 32'(bus.irq_id_o[0]), 32'd4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ip", bus.ip_o, 32'h0);
    check("mid_rst_irq", 32'(bus.irq_o), 32'h0);
    check("mid_rst_id", 32'(bus.irq_id_o), 32'h0);
    check("mid_rst_claim", 32'(bus.claim_id_o), 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_ip", 32'(bus.ip_o[4:3]), 32'h3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
